// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back formatter for the RV32I pipeline.
// Selects the write-back source, formats loads, flags bad loads and counts retirements.
module mem_wb_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic                     mem_reg_write,
    input  logic [1:0]               mem_wb_sel,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_alu_result,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic [2:0]               mem_funct3,
    input  logic [DATA_WIDTH-1:0]    mem_pc_plus4,
    input  logic [DATA_WIDTH-1:0]    mem_imm,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     RegWrite,
    output logic [ADDRESS_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0]    WriteData,
    output logic                     wb_valid,
    output logic                     load_fault,
    output logic [CNT_WIDTH-1:0]     retire_count
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_IMM  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] ext8(input logic [7:0] b, input logic sgn);
        ext8 = {{(DATA_WIDTH-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ext16(input logic [15:0] h, input logic sgn);
        ext16 = {{(DATA_WIDTH-16){sgn & h[15]}}, h};
    endfunction

    logic [1:0]               w_off;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic                     w_bad_load;
    logic                     w_fault;
    logic [DATA_WIDTH-1:0]    w_wb_data;
    logic                     w_reg_write;

    logic                     r_reg_write;
    logic [ADDRESS_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]    r_data;
    logic                     r_valid;
    logic                     r_fault;
    logic [CNT_WIDTH-1:0]     r_retire;

    // Load lane selection, extension, fault detection and write-back source mux.
    always_comb begin
        w_off = mem_alu_result[1:0];

        case (w_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase

        if (w_off[1]) begin
            w_half = mem_rdata[31:16];
        end else begin
            w_half = mem_rdata[15:0];
        end

        w_load_data = {DATA_WIDTH{1'b0}};
        w_bad_load  = 1'b0;
        case (mem_funct3)
            F3_LB:  w_load_data = ext8(w_byte, 1'b1);
            F3_LBU: w_load_data = ext8(w_byte, 1'b0);
            F3_LH: begin
                w_load_data = ext16(w_half, 1'b1);
                w_bad_load  = w_off[0];
            end
            F3_LHU: begin
                w_load_data = ext16(w_half, 1'b0);
                w_bad_load  = w_off[0];
            end
            F3_LW: begin
                w_load_data = mem_rdata;
                w_bad_load  = (w_off != 2'd0);
            end
            default: begin
                w_load_data = {DATA_WIDTH{1'b0}};
                w_bad_load  = 1'b1;
            end
        endcase

        // Faults only matter for a real load; bubbles and non-loads never flag.
        w_fault = mem_valid & (mem_wb_sel == SEL_LOAD) & w_bad_load;

        case (mem_wb_sel)
            SEL_ALU:  w_wb_data = mem_alu_result;
            SEL_LOAD: w_wb_data = w_load_data;
            SEL_PC4:  w_wb_data = mem_pc_plus4;
            SEL_IMM:  w_wb_data = mem_imm;
            default:  w_wb_data = mem_alu_result;
        endcase

        w_reg_write = mem_valid & mem_reg_write & (mem_rd != {ADDRESS_WIDTH{1'b0}}) & ~w_fault;
    end

    // Pipeline register with rst > flush > stall > capture priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_rd        <= {ADDRESS_WIDTH{1'b0}};
            r_data      <= {DATA_WIDTH{1'b0}};
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
            r_retire    <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            r_reg_write <= 1'b0;
            r_rd        <= {ADDRESS_WIDTH{1'b0}};
            r_data      <= {DATA_WIDTH{1'b0}};
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
        end else if (!stall) begin
            r_reg_write <= w_reg_write;
            r_rd        <= mem_rd;
            r_data      <= w_wb_data;
            r_valid     <= mem_valid;
            r_fault     <= w_fault;
            if (mem_valid) begin
                r_retire <= r_retire + CNT_ONE;
            end
        end
    end

    assign RegWrite      = r_reg_write;
    assign WriteRegister = r_rd;
    assign WriteData     = r_data;
    assign wb_valid      = r_valid;
    assign load_fault    = r_fault;
    assign retire_count  = r_retire;

endmodule
